// File: rtl/wb_boot_arbiter.sv
// Two-master Wishbone arbiter: bootloader (m0) / CPU (m1).
// Boot-mode lockout, round-robin on ties, wait-state timeout abort.
module wb_boot_arbiter #(
  parameter int WB_DATA = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                 wb_clk,
  input  logic                 rst,
  input  logic                 boot_mode,

  input  logic                 m0_cyc_i,
  input  logic                 m0_stb_i,
  input  logic                 m0_we_i,
  input  logic [WB_DATA-1:0]   m0_adr_i,
  input  logic [WB_DATA-1:0]   m0_dat_i,
  input  logic [WB_DATA/8-1:0] m0_sel_i,
  input  logic [2:0]           m0_cti_i,
  input  logic [1:0]           m0_bte_i,
  output logic                 m0_ack_o,
  output logic                 m0_err_o,
  output logic                 m0_rty_o,
  output logic [WB_DATA-1:0]   m0_dat_o,

  input  logic                 m1_cyc_i,
  input  logic                 m1_stb_i,
  input  logic                 m1_we_i,
  input  logic [WB_DATA-1:0]   m1_adr_i,
  input  logic [WB_DATA-1:0]   m1_dat_i,
  input  logic [WB_DATA/8-1:0] m1_sel_i,
  input  logic [2:0]           m1_cti_i,
  input  logic [1:0]           m1_bte_i,
  output logic                 m1_ack_o,
  output logic                 m1_err_o,
  output logic                 m1_rty_o,
  output logic [WB_DATA-1:0]   m1_dat_o,

  output logic                 s_cyc_o,
  output logic                 s_stb_o,
  output logic                 s_we_o,
  output logic [WB_DATA-1:0]   s_adr_o,
  output logic [WB_DATA-1:0]   s_dat_o,
  output logic [WB_DATA/8-1:0] s_sel_o,
  output logic [2:0]           s_cti_o,
  output logic [1:0]           s_bte_o,
  input  logic                 s_ack_i,
  input  logic                 s_err_i,
  input  logic                 s_rty_i,
  input  logic [WB_DATA-1:0]   s_dat_i,

  output logic [1:0]           grant,
  output logic                 timeout_err
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    GRANT_M0 = 2'd1,
    GRANT_M1 = 2'd2,
    ABORT    = 2'd3
  } state_e;

  localparam logic [15:0] TMO = 16'(TIMEOUT);

  state_e      state_q, state_d;
  logic        last_q, last_d;
  logic [15:0] cnt_q, cnt_d;
  logic        first_q, first_d;

  logic resp;
  logic own_cyc;
  logic own_stb;

  assign resp = s_ack_i | s_err_i | s_rty_i;

  // last_q tracks the owner while granted or aborting
  assign own_cyc = last_q ? m1_cyc_i : m0_cyc_i;
  assign own_stb = last_q ? m1_stb_i : m0_stb_i;

  always_ff @(posedge wb_clk) begin
    if (rst) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      cnt_q   <= '0;
      first_q <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      first_q <= first_d;
    end
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    first_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (m0_cyc_i &&
            (boot_mode || !m1_cyc_i || last_q)) begin
          state_d = GRANT_M0;
          last_d  = 1'b0;
        end else if (m1_cyc_i && !boot_mode) begin
          state_d = GRANT_M1;
          last_d  = 1'b1;
        end
      end
      GRANT_M0,
      GRANT_M1: begin
        if (!own_cyc) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (resp) begin
          cnt_d = '0;
        end else if (cnt_q >= TMO) begin
          state_d = ABORT;
          first_d = 1'b1;
          cnt_d   = '0;
        end else if (own_stb) begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      ABORT: begin
        cnt_d = '0;
        if (!own_cyc) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  logic sel0, sel1, abrt;

  assign sel0 = (state_q == GRANT_M0);
  assign sel1 = (state_q == GRANT_M1);
  assign abrt = (state_q == ABORT);

  always_comb begin
    s_cyc_o     = 1'b0;
    s_stb_o     = 1'b0;
    s_we_o      = 1'b0;
    s_adr_o     = '0;
    s_dat_o     = '0;
    s_sel_o     = '0;
    s_cti_o     = '0;
    s_bte_o     = '0;
    m0_ack_o    = 1'b0;
    m0_err_o    = 1'b0;
    m0_rty_o    = 1'b0;
    m0_dat_o    = '0;
    m1_ack_o    = 1'b0;
    m1_err_o    = 1'b0;
    m1_rty_o    = 1'b0;
    m1_dat_o    = '0;
    grant       = 2'b00;
    timeout_err = 1'b0;
    unique case (1'b1)
      sel0: begin
        grant    = 2'b01;
        s_cyc_o  = m0_cyc_i;
        s_stb_o  = m0_stb_i;
        s_we_o   = m0_we_i;
        s_adr_o  = m0_adr_i;
        s_dat_o  = m0_dat_i;
        s_sel_o  = m0_sel_i;
        s_cti_o  = m0_cti_i;
        s_bte_o  = m0_bte_i;
        m0_ack_o = s_ack_i;
        m0_err_o = s_err_i;
        m0_rty_o = s_rty_i;
        m0_dat_o = s_dat_i;
      end
      sel1: begin
        grant    = 2'b10;
        s_cyc_o  = m1_cyc_i;
        s_stb_o  = m1_stb_i;
        s_we_o   = m1_we_i;
        s_adr_o  = m1_adr_i;
        s_dat_o  = m1_dat_i;
        s_sel_o  = m1_sel_i;
        s_cti_o  = m1_cti_i;
        s_bte_o  = m1_bte_i;
        m1_ack_o = s_ack_i;
        m1_err_o = s_err_i;
        m1_rty_o = s_rty_i;
        m1_dat_o = s_dat_i;
      end
      abrt: begin
        grant       = last_q ? 2'b10 : 2'b01;
        timeout_err = first_q;
        m0_err_o    = first_q & ~last_q;
        m1_err_o    = first_q & last_q;
      end
      default: ;
    endcase
  end

endmodule

// File: doc/wb_boot_arbiter.md
WB_BOOT_ARBITER -- requirements
Module: wb_boot_arbiter

Interface
REQ-001 Parameter WB_DATA, default 32: Wishbone data/address width.
REQ-002 Parameter TIMEOUT, default 255: max wait cycles per transfer before a forced error; legal range 1..65535.
REQ-003 wb_clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 boot_mode  input  1  high = only master 0 (bootloader) may be granted.
REQ-006 m0_cyc_i, m0_stb_i, m0_we_i  input  1 each  master 0 (bootloader) strobes.
REQ-007 m0_adr_i, m0_dat_i  input  WB_DATA each; m0_sel_i  input  WB_DATA/8; m0_cti_i  input  3; m0_bte_i  input  2.
REQ-008 m0_ack_o, m0_err_o, m0_rty_o  output  1 each; m0_dat_o  output  WB_DATA.
REQ-009 m1_* (CPU master): same ports, widths and directions as REQ-006..REQ-008.
REQ-010 s_cyc_o, s_stb_o, s_we_o  output  1; s_adr_o, s_dat_o  output  WB_DATA; s_sel_o  output  WB_DATA/8; s_cti_o  output  3; s_bte_o  output  2.
REQ-011 s_ack_i, s_err_i, s_rty_i  input  1; s_dat_i  input  WB_DATA.
REQ-012 grant  output  2  one-hot owner {m1,m0}; 2'b00 = bus idle.
REQ-013 timeout_err  output  1  one-cycle pulse when a transfer is aborted by timeout.

Function
REQ-014 FSM states: IDLE, GRANT_M0, GRANT_M1, ABORT; state held in a registered state variable.
REQ-015 IDLE: grant = 00; all s_* outputs 0; all m*_ack/err/rty 0.
REQ-016 IDLE arbitration: boot_mode=1 -> only m0_cyc_i considered, m1 never granted.
REQ-017 IDLE arbitration, boot_mode=0: single requester granted; both requesting -> grant the master not granted last (round-robin); after reset last-granted = m1, so m0 wins first tie.
REQ-018 Grant latency: exactly one cycle from cyc sampled high in IDLE to GRANT_Mx; no slave strobe in the arbitration cycle.
REQ-019 GRANT_Mx: s_* outputs combinationally equal granted master's inputs; granted master's ack/err/rty/dat = slave's; non-granted master sees ack/err/rty = 0, dat = 0.
REQ-020 Grant held while granted master's cyc_i = 1 (locked across multi-beat and back-to-back cycles); cyc_i = 0 -> IDLE next cycle, last-granted updated.
REQ-021 boot_mode rising during GRANT_M1: current m1 cycle completes; m1 not re-granted.
REQ-022 Wait counter, 16 bits: cleared in IDLE and on any cycle with s_ack_i|s_err_i|s_rty_i; increments each cycle granted stb_i = 1 with no response.
REQ-023 Counter reaching TIMEOUT -> ABORT next cycle; s_cyc_o/s_stb_o = 0 from that cycle.
REQ-024 ABORT, first cycle: granted master's err_o = 1 and timeout_err = 1 for exactly one cycle; ack_o = 0.
REQ-025 ABORT: stay, grant unchanged, s_* = 0, until granted master drops cyc_i -> IDLE.
REQ-026 Slave response coinciding with counter = TIMEOUT: response wins, forwarded normally, no abort.
REQ-027 Slave ack/err/rty in IDLE or ABORT: ignored, not forwarded to either master.
REQ-028 Arithmetic: counter saturates at TIMEOUT, never wraps.

Reset
REQ-029 rst = 1 at a clock edge -> state IDLE, counter 0, last-granted = m1, grant = 00, timeout_err = 0; all s_* and m*_ack/err/rty/dat outputs 0 while in IDLE.
REQ-030 rst mid-transfer aborts without err to either master; slave sees cyc drop next cycle.

Verification
REQ-031 boot_mode=1, m0 writes 0xDEADBEEF to 0x92000000, m1_cyc=1 throughout -> grant=01, s_dat_o=0xDEADBEEF, m0_ack once, m1_ack never.
REQ-032 boot_mode=0, both cyc rise same cycle after reset -> grant=01 first; on m0 release, grant=10 next-but-one cycle; repeat -> 01 again.
REQ-033 TIMEOUT=4, slave never acks -> m0_err_o and timeout_err high once, 5 cycles after stb, s_stb_o=0; m0 drops cyc -> grant=00.
REQ-034 TIMEOUT=4, s_ack_i on the 4th wait cycle -> m0_ack_o=1, no err, timeout_err=0.
REQ-035 m1 4-beat burst (cti=010) with m0 requesting -> m1 keeps grant all 4 beats; m0 granted only after m1_cyc=0.
REQ-036 rst during GRANT_M1 wait state -> next cycle grant=00, s_cyc_o=0, m1_err_o=0.
